// File: rtl/uart_rx_cfg_pkg.sv
// Shared types and constants for the configurable-frame UART receiver.
package uart_rx_cfg_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [5:0] PRESCALE_MIN = 6'd8;
  localparam logic       EVEN         = 1'b0;
  localparam logic       ODD          = 1'b1;

  function automatic logic [5:0] eff_prescale(input logic [5:0] p);
    return (p < PRESCALE_MIN) ? PRESCALE_MIN : p;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX synchroniser, per-bit edge/bit counters and majority-of-3 mid-bit voter.
module uart_rx_sampler #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  input  logic [5:0] prescale,
  input  logic       run,
  input  logic       clear,
  output logic       rx_s,
  output logic       voted_bit,
  output logic       sample_strobe,
  output logic       bit_done,
  output logic [3:0] bit_cnt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [5:0]             edge_cnt;
  logic [5:0]             half;
  logic [2:0]             smp;

  assign half = {1'b0, prescale[5:1]};
  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
  end

  assign bit_done      = run && (edge_cnt == prescale - 6'd1);
  assign sample_strobe = run && (edge_cnt == half + 6'd2);
  assign voted_bit     = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
      smp      <= '0;
    end else if (clear) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (run) begin
      if (bit_done) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + 6'd1;
      end
      if (edge_cnt == half - 6'd1) smp[0] <= rx_s;
      if (edge_cnt == half)        smp[1] <= rx_s;
      if (edge_cnt == half + 6'd1) smp[2] <= rx_s;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable-frame UART receiver: frame FSM, shift register and valid/ready holding register.
module uart_rx_cfg
  import uart_rx_cfg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic                  data_ready,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  overrun_error
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH);

  state_t                state, state_nxt;
  logic [5:0]            p_l;
  logic                  par_en_l, par_typ_l, stop2_l;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_flag, frm_flag, stop_second;
  logic                  start_frame, frame_done, par_exp;
  logic                  rx_s, voted_bit, sample_strobe, bit_done;
  logic [3:0]            bit_cnt;

  uart_rx_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sampler (
    .clk           (clk),
    .reset         (reset),
    .rx_in         (RX_IN),
    .prescale      (p_l),
    .run           (state != IDLE),
    .clear         (start_frame),
    .rx_s          (rx_s),
    .voted_bit     (voted_bit),
    .sample_strobe (sample_strobe),
    .bit_done      (bit_done),
    .bit_cnt       (bit_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    frame_done  = 1'b0;
    case (state)
      IDLE: if (!rx_s) begin
        state_nxt   = START;
        start_frame = 1'b1;
      end
      START: begin
        if (sample_strobe && voted_bit) state_nxt = IDLE;
        else if (bit_done)              state_nxt = DATA;
      end
      DATA: if (bit_done && bit_cnt == LAST_DATA) state_nxt = par_en_l ? PARITY : STOP;
      PARITY: if (bit_done) state_nxt = STOP;
      // completes mid-way through the last stop bit so a back-to-back start edge is seen
      STOP: if (sample_strobe && (!stop2_l || stop_second)) begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    par_exp = ^shreg;
    case (par_typ_l)
      EVEN: par_exp = ^shreg;
      ODD:  par_exp = ~^shreg;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_l         <= PRESCALE_MIN;
      par_en_l    <= 1'b0;
      par_typ_l   <= EVEN;
      stop2_l     <= 1'b0;
      shreg       <= '0;
      par_flag    <= 1'b0;
      frm_flag    <= 1'b0;
      stop_second <= 1'b0;
    end else if (start_frame) begin
      p_l         <= eff_prescale(Prescale);
      par_en_l    <= PAR_EN;
      par_typ_l   <= PAR_TYP;
      stop2_l     <= STOP2;
      par_flag    <= 1'b0;
      frm_flag    <= 1'b0;
      stop_second <= 1'b0;
    end else begin
      case (state)
        DATA:   if (sample_strobe) shreg <= {voted_bit, shreg[DATA_WIDTH-1:1]};
        PARITY: if (sample_strobe && (voted_bit != par_exp)) par_flag <= 1'b1;
        STOP: begin
          if (sample_strobe && !voted_bit) frm_flag <= 1'b1;
          if (bit_done) stop_second <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      P_DATA        <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      overrun_error <= 1'b0;
      if (frame_done && (!data_valid || data_ready)) begin
        P_DATA        <= shreg;
        parity_error  <= par_flag;
        framing_error <= frm_flag | ~voted_bit;
        data_valid    <= 1'b1;
      end else begin
        if (frame_done) overrun_error <= 1'b1;
        if (data_valid && data_ready) data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: an 8-bit and a 7-bit instance driven with serial frames.
module tb_uart_rx_cfg;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx8, rx7;
  logic [5:0] Prescale;
  logic       PAR_EN, PAR_TYP, STOP2;
  logic       data_ready = 1'b0;
  logic [7:0] pd8;
  logic [6:0] pd7;
  logic       dv8, pe8, fe8, ov8;
  logic       dv7, pe7, fe7, ov7;

  always #5 clk = ~clk;

  uart_rx_cfg #(.DATA_WIDTH(8), .SYNC_STAGES(SYNC)) dut8 (
    .clk(clk), .reset(reset), .RX_IN(rx8), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .STOP2(STOP2), .data_ready(data_ready), .P_DATA(pd8),
    .data_valid(dv8), .parity_error(pe8), .framing_error(fe8), .overrun_error(ov8)
  );

  uart_rx_cfg #(.DATA_WIDTH(7), .SYNC_STAGES(SYNC)) dut7 (
    .clk(clk), .reset(reset), .RX_IN(rx7), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .STOP2(STOP2), .data_ready(data_ready), .P_DATA(pd7),
    .data_valid(dv7), .parity_error(pe7), .framing_error(fe7), .overrun_error(ov7)
  );

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t q8[$];
  exp_t q7[$];
  int total = 0, bad = 0;
  int ovr_seen8 = 0, ovr_seen7 = 0, ovr_exp8 = 0, ovr_exp7 = 0;
  int ready_mode = 0;   // 0 random, 1 held low, 2 held high

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      1:       data_ready = 1'b0;
      2:       data_ready = 1'b1;
      default: data_ready = 1'($urandom % 2);
    endcase
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (reset) begin
      if (ov8) ovr_seen8++;
      if (dv8 && data_ready) begin
        if (q8.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious8: got word %0h expected none at %0t", pd8, $time);
        end else begin
          e = q8.pop_front();
          check("data8", int'(pd8), int'(e.data[7:0]));
          check("perr8", int'(pe8), int'(e.perr));
          check("ferr8", int'(fe8), int'(e.ferr));
        end
      end
    end
  end

  always @(negedge clk) begin : mon7
    exp_t e;
    if (reset) begin
      if (ov7) ovr_seen7++;
      if (dv7 && data_ready) begin
        if (q7.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious7: got word %0h expected none at %0t", pd7, $time);
        end else begin
          e = q7.pop_front();
          check("data7", int'(pd7), int'(e.data[6:0]));
          check("perr7", int'(pe7), int'(e.perr));
          check("ferr7", int'(fe7), int'(e.ferr));
        end
      end
    end
  end

  task automatic set_rx(input int which, input logic b);
    if (which == 0) rx8 = b;
    else            rx7 = b;
  endtask

  // Builds one frame from the configuration inputs, queues its expected result, drives it.
  task automatic send(input int which, input logic [8:0] data, input logic wrong_par,
                      input logic [1:0] stops, input int spike, input bit push);
    int         w, p, n;
    logic [8:0] d;
    logic       ep;
    logic [12:0] bits;
    exp_t       e;
    w = (which == 0) ? 8 : 7;
    p = (Prescale < 6'd8) ? 8 : int'(Prescale);
    d = data & ((9'd1 << w) - 9'd1);
    ep = 1'($countones(d) % 2) ^ PAR_TYP;
    e.data = d;
    e.perr = PAR_EN & wrong_par;
    e.ferr = !stops[0] || (STOP2 && !stops[1]);
    if (push) begin
      if (which == 0) q8.push_back(e);
      else            q7.push_back(e);
    end
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < w; i++) bits[1+i] = d[i];
    n = 1 + w;
    if (PAR_EN) begin bits[n] = ep ^ wrong_par; n++; end
    bits[n] = stops[0]; n++;
    if (STOP2) begin bits[n] = stops[1]; n++; end
    for (int i = 0; i < n; i++) begin
      set_rx(which, bits[i]);
      if (i == spike) begin
        repeat (p/2 + 1) @(negedge clk);
        set_rx(which, 1'b0);
        @(negedge clk);
        set_rx(which, bits[i]);
        repeat (p - p/2 - 2) @(negedge clk);
      end else begin
        repeat (p) @(negedge clk);
      end
    end
    set_rx(which, 1'b1);
    // a low final stop bit looks like a fresh start edge; let it die out as a glitch
    if (!bits[n-1]) repeat (2*p + 4) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((q8.size() != 0 || q7.size() != 0 || dv8 || dv7) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 3000) begin
      bad++;
      $display("FAIL drain_timeout: got %0d/%0d words pending expected 0", q8.size(), q7.size());
    end
  endtask

  task automatic cfg(input logic [5:0] p, input logic pe, input logic pt, input logic s2);
    Prescale = p; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1);
  end

  initial begin
    int lat;
    reset = 1'b0; rx8 = 1'b1; rx7 = 1'b1;
    cfg(6'd8, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_pdata", int'(pd8), 0);
    check("rst_valid", int'(dv8), 0);
    check("rst_perr", int'(pe8), 0);
    check("rst_ferr", int'(fe8), 0);
    check("rst_ovr", int'(ov8), 0);
    check("rst_valid7", int'(dv7), 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // latency from the start edge on the pin to data_valid
    ready_mode = 1;
    lat = 0;
    fork
      send(0, 9'h0A5, 1'b0, 2'b11, -1, 1'b1);
      begin
        while (!dv8 && lat < 300) begin @(posedge clk); #1; lat++; end
      end
    join
    check("latency", lat, 9*8 + 4 + SYNC + 4);
    ready_mode = 0;
    drain();

    for (int i = 0; i < 15; i++) begin
      cfg(6'($urandom_range(4, 24)), 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
      send(0, 9'($urandom), 1'($urandom_range(0, 3) == 0),
           {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)}, -1, 1'b1);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    drain();

    cfg(6'd16, 1'b1, 1'b0, 1'b0);
    send(1, 9'h055, 1'b1, 2'b11, -1, 1'b1);
    send(1, 9'h055, 1'b0, 2'b11, -1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cfg(6'($urandom_range(8, 20)), 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
      send(1, 9'($urandom), 1'($urandom_range(0, 2) == 0),
           {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)}, -1, 1'b1);
    end
    drain();

    cfg(6'd32, 1'b0, 1'b0, 1'b1);
    send(0, 9'h03C, 1'b0, 2'b01, -1, 1'b1);
    send(0, 9'h03C, 1'b0, 2'b11, -1, 1'b1);
    drain();

    cfg(6'd8, 1'b0, 1'b0, 1'b0);
    ready_mode = 1;
    send(0, 9'h011, 1'b0, 2'b11, -1, 1'b1);
    send(0, 9'h022, 1'b0, 2'b11, -1, 1'b0);
    ovr_exp8++;
    repeat (12) @(negedge clk);
    check("ovr_hold_data", int'(pd8), 'h11);
    check("ovr_hold_valid", int'(dv8), 1);
    check("ovr_pulse_count", ovr_seen8, ovr_exp8);
    ready_mode = 2;
    send(0, 9'h033, 1'b0, 2'b11, -1, 1'b1);
    ready_mode = 0;
    drain();

    cfg(6'd16, 1'b0, 1'b0, 1'b0);
    rx8 = 1'b0;
    repeat (3) @(negedge clk);
    rx8 = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_no_valid", int'(dv8), 0);
    send(0, 9'h00F, 1'b0, 2'b11, 2, 1'b1);
    drain();

    fork
      send(0, 9'h0FF, 1'b0, 2'b11, -1, 1'b0);
      begin
        repeat (40) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_pdata", int'(pd8), 0);
        check("midrst_valid", int'(dv8), 0);
        reset = 1'b1;
      end
    join
    fork
      send(0, 9'h081, 1'b0, 2'b11, -1, 1'b1);
      begin
        repeat (40) @(negedge clk);
        Prescale = 6'd8;
      end
    join
    drain();

    repeat (20) @(negedge clk);
    check("ovr8_count", ovr_seen8, ovr_exp8);
    check("ovr7_count", ovr_seen7, ovr_exp7);
    check("words_left", q8.size() + q7.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised, configurable-frame UART receiver, successor to the fixed 8-bit receiver in the UART subsystem. It adds:
- a parametrised data width
- selectable 1 or 2 stop bits
- majority-of-3 mid-bit sampling
- an RX_IN synchroniser
- a valid/ready output holding register with overrun detection

It sits between the async RX pin and the system-side register file / FIFO.

Parameters:
DATA_WIDTH, 8, payload bits per frame; legal 5..9.
SYNC_STAGES, 2, RX_IN synchroniser depth; legal 2..3.

Ports:
clk  in  1  single receive clock (oversampling clock).
reset  in  1  asynchronous, active-low reset.
RX_IN  in  1  serial line, idle high, async to clk.
Prescale  in  6  oversampling ratio (clk edges per bit).
PAR_EN  in  1  1 = parity bit present.
PAR_TYP  in  1  0 = even, 1 = odd.
STOP2  in  1  1 = two stop bits.
data_ready  in  1  consumer accepts P_DATA this cycle.
P_DATA  out  DATA_WIDTH  received word, LSB first on line.
data_valid  out  1  holding register full.
parity_error  out  1  parity flag of held word.
framing_error  out  1  stop-bit flag of held word.
overrun_error  out  1  one-cycle pulse: completed frame dropped.

Behaviour:
- Reset (reset=0, async):
  - State IDLE; synchroniser flops = 1; counters = 0.
  - Outputs: P_DATA = 0, data_valid = 0, parity_error = 0, framing_error = 0, overrun_error = 0.
  - Reset mid-frame aborts the frame with no flags.
- Config latch: Prescale, PAR_EN, PAR_TYP and STOP2 are latched on leaving IDLE. Changes mid-frame have no effect.
- Prescale handling: effective P = max(Prescale, 8). Let H = floor(P/2).
- Counters:
  - edge_cnt counts 0..P-1 and wraps.
  - bit_cnt increments on each wrap.
  - Both clear on entering START.
- Sampling: rx_s is the synchronised RX_IN. It is sampled at edge_cnt = H-1, H and H+1. The bit value is the majority of the three samples, valid from edge_cnt = H+2.
- FSM:
  - IDLE: rx_s = 0 → START.
  - START: at edge_cnt = H+2:
    - voted bit = 1 → glitch, go to IDLE, no flags, nothing delivered.
    - voted bit = 0 → continue START until edge_cnt = P-1, then → DATA.
  - DATA: shift voted bit in LSB-first at H+2 of each bit. After DATA_WIDTH bits, at edge wrap → PARITY if latched PAR_EN, else → STOP.
  - PARITY: expected parity = XOR(data) for even, ~XOR(data) for odd. Mismatch sets the frame parity flag. → STOP at wrap.
  - STOP: voted bit 0 sets the frame framing flag.
    - With STOP2, the first stop bit completes at wrap, then the second is sampled.
    - At H+2 of the last stop bit, the frame completes and the FSM → IDLE. A back-to-back start bit is therefore caught.
- Frame completion at cycle t:
  - Output register empty, or data_valid & data_ready at t: at t+1, P_DATA/flags are loaded and data_valid = 1.
  - Output register full and not released at t: frame dropped, held word unchanged, overrun_error = 1 for exactly cycle t+1.
- Handshake:
  - Transfer occurs on data_valid & data_ready.
  - data_valid drops the next cycle unless a new frame loads in the same cycle.
  - P_DATA and the flags hold stable while data_valid = 1.
- Frame latency: last stop bit start + H+2 edges + 1 cycle → data_valid.
- A frame with both errors reports both flags. The word is delivered regardless of errors.

Decomposition:
- Package uart_rx_cfg_pkg:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - PRESCALE_MIN = 8.
  - Parity-type constants EVEN = 0, ODD = 1.
- One sub-module, uart_rx_sampler: synchroniser, edge/bit counters and majority voter. It outputs voted_bit and sample_strobe (the H+2 strobe) and bit_done (the wrap strobe).
- FSM, shift register and output holding register stay in the top level.

Test Plan:
- DATA_WIDTH = 8, P = 8, no parity, 1 stop; send 0xA5 → data_valid after the stop mid-point, P_DATA = 0xA5, both error flags 0.
- DATA_WIDTH = 7, P = 16, PAR_EN = 1, PAR_TYP = 0; send 0x55 with parity bit 1 (wrong) → P_DATA = 0x55, parity_error = 1. Resend with parity 0 → parity_error = 0.
- STOP2 = 1, P = 32; send 0x3C with second stop bit driven 0 → framing_error = 1. Repeat with both stops 1 → framing_error = 0.
- data_ready held 0; send 0x11 then 0x22 → P_DATA stays 0x11, overrun_error pulses once. Raise data_ready → next word delivered is the following frame 0x33.
- Start pulse low for 3 edges at P = 16 → no data_valid, FSM back in IDLE. Then a 1-edge low spike mid-bit of a 0x0F data bit → majority vote keeps P_DATA = 0x0F.
- Assert reset mid-DATA of 0xFF, release, then send 0x81 → only 0x81 is delivered, no flags. Also change Prescale 16→8 mid-frame → the current frame still decodes correctly at 16.
